imem_stream_loader: RTL

- Parametrised instruction-memory controller with an internal inferred single-clock RAM.
- Serves fetch-stage reads in normal operation.
- Accepts a word stream from the UART word assembler to reprogram memory. Entry uses a configurable START magic word. Exit uses an END magic word followed by a checksum word.
- Reports word count, completion and error status to the core and debug logic. Replaces the derived-clock memory scheme: all logic and RAM run on clk only.

---
 rtl/imem_stream_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: instruction RAM serving fetch reads, reprogrammable from a START/END-framed word stream
module imem_stream_loader #(
  parameter int DW = 32,
  parameter int AW = 10,
  parameter logic [DW-1:0] START_WORD = 32'hDEADBEEF,
  parameter logic [DW-1:0] END_WORD = 32'hBADDAB99,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          prog_valid,
  input  logic [DW-1:0] prog_data,
  output logic          state_load_prog,
  output logic [AW:0]   prog_count,
  output logic          prog_done,
  output logic          prog_err,
  output logic [1:0]    err_code
);
  localparam int DEPTH = 2 ** AW;
  typedef enum logic [1:0] {RUN, LOAD, CHECK} state_t;
  state_t state, state_n;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] ptr;
  logic [DW-1:0] acc;
  logic ovf, start, wr, drop, fin, bad;
  always_comb begin
    state_n = state;
    start = 1'b0;
    wr = 1'b0;
    drop = 1'b0;
    fin = 1'b0;
    bad = 1'b0;
    case (state)
      RUN: if (prog_valid && prog_data == START_WORD) begin
        state_n = LOAD;
        start = 1'b1;
      end
      LOAD: if (prog_valid) begin
        if (prog_data == END_WORD) begin
          state_n = CHECK_EN ? CHECK : RUN;
          fin = !CHECK_EN;
        end else begin
          drop = ptr[AW];
          wr = !ptr[AW];
        end
      end
      CHECK: if (prog_valid) begin
        state_n = RUN;
        fin = 1'b1;
        bad = prog_data != acc;
      end
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk)
    if (wr) mem[ptr[AW-1:0]] <= prog_data;
  // ptr only ever counts stored words, so it doubles as prog_count
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      state_load_prog <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      ptr <= '0;
      acc <= '0;
      ovf <= 1'b0;
      prog_done <= 1'b0;
      prog_err <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state <= state_n;
      state_load_prog <= state_n != RUN;
      rd_valid <= state == RUN && rd_en;
      if (state == RUN && rd_en) rd_data <= mem[rd_addr];
      if (start) begin
        ptr <= '0;
        acc <= '0;
        ovf <= 1'b0;
        prog_done <= 1'b0;
        prog_err <= 1'b0;
        err_code <= 2'b00;
      end else begin
        if (wr) ptr <= ptr + 1'b1;
        if (wr) acc <= acc + prog_data;
        if (drop) ovf <= 1'b1;
        if (fin) begin
          prog_err <= ovf || bad;
          prog_done <= !(ovf || bad);
          err_code <= ovf ? 2'b01 : bad ? 2'b10 : 2'b00;
        end
      end
    end
  assign prog_count = ptr;
endmodule
